// File: rtl/simple_fixed_point_unsigned_long_multiplication.sv
// Shift-add unsigned Q-format multiplier, one multiplier bit per clock, saturating result.
// Build option SIMPLE_FIXED_POINT_UNSIGNED_LONG_MULTIPLICATION_ROUND_EN selects round-half-up instead of truncation.
module simple_fixed_point_unsigned_long_multiplication #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_multiplicand,
  input  logic [WIDTH-1:0] i_multiplier,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_product,
  output logic             o_overflow
);

  // state | meaning
  // IDLE  | waiting for operands, o_ready high
  // RUN   | one shift-add iteration per clock, WIDTH iterations
  // DONE  | scale/saturate accumulator, register result, strobe o_valid
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [AW-1:0]        acc_rnd;
  logic [AW-FRAC-1:0]   q;
  logic                 ovf;
  logic [WIDTH-1:0]     prod_sat;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt counts remaining iterations down to a terminal count of zero
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
      o_valid    <= 1'b0;
      o_product  <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sh <= {{WIDTH{1'b0}}, i_multiplicand};
            b_sh <= i_multiplier;
            acc  <= '0;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          o_product  <= prod_sat;
          o_overflow <= ovf;
          o_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIMPLE_FIXED_POINT_UNSIGNED_LONG_MULTIPLICATION_ROUND_EN
  generate
    if (FRAC > 0) begin : g_round
      assign acc_rnd = {1'b0, acc} + (AW'(1) << (FRAC - 1));
    end else begin : g_noround
      assign acc_rnd = {1'b0, acc};
    end
  endgenerate
`else
  assign acc_rnd = {1'b0, acc};
`endif

  // the rounding carry lands in q before the range check, so it can saturate
  assign q        = acc_rnd[AW-1:FRAC];
  assign ovf      = |q[AW-FRAC-1:WIDTH];
  assign prod_sat = ovf ? {WIDTH{1'b1}} : q[WIDTH-1:0];

  assign o_ready = (state == IDLE);

endmodule

// File: tb/tb_simple_fixed_point_unsigned_long_multiplication.sv
// Directed bench for the shift-add fixed-point multiplier (WIDTH=8, FRAC=4).
// Expectations follow SIMPLE_FIXED_POINT_UNSIGNED_LONG_MULTIPLICATION_ROUND_EN when it is defined.
module tb_simple_fixed_point_unsigned_long_multiplication;
  localparam int WIDTH = 8;
  localparam int FRAC  = 4;
`ifdef SIMPLE_FIXED_POINT_UNSIGNED_LONG_MULTIPLICATION_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_valid;
  logic [WIDTH-1:0] i_multiplicand;
  logic [WIDTH-1:0] i_multiplier;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_product;
  logic             o_overflow;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  simple_fixed_point_unsigned_long_multiplication #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_multiplicand(i_multiplicand),
    .i_multiplier  (i_multiplier),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_product     (o_product),
    .o_overflow    (o_overflow)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prod;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // drive operands at negedge, leave the task just after the accept edge E0
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    @(negedge i_clk);
    i_multiplicand = a;
    i_multiplier   = b;
    i_valid        = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("ready_low_in_run", {31'd0, o_ready}, 32'd0);
  endtask

  // returns the number of edges after the current point until o_valid, -1 on timeout
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start(v.a, v.b);
    wait_result(lat);
    chk($sformatf("latency[%0d]", idx), lat, 9);
    chk($sformatf("product[%0d]", idx), {24'd0, o_product}, {24'd0, v.prod});
    chk($sformatf("overflow[%0d]", idx), {31'd0, o_overflow}, {31'd0, v.ovf});
    chk($sformatf("ready_with_valid[%0d]", idx), {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{8'h28, 8'h18, 8'h3C, 1'b0};
    vecs[1]  = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
    vecs[2]  = '{8'h10, 8'h10, 8'h10, 1'b0};
    vecs[3]  = '{8'h01, 8'h08, RND ? 8'h01 : 8'h00, 1'b0};
    vecs[4]  = '{8'h01, 8'h07, 8'h00, 1'b0};
    vecs[5]  = '{8'h00, 8'hAB, 8'h00, 1'b0};
    vecs[6]  = '{8'h0F, 8'h11, RND ? 8'h10 : 8'h0F, 1'b0};
    vecs[7]  = '{8'h80, 8'h02, 8'h10, 1'b0};
    vecs[8]  = '{8'hFF, 8'h10, 8'hFF, 1'b0};
    vecs[9]  = '{8'hFF, 8'h11, 8'hFF, 1'b1};
    vecs[10] = '{8'h3F, 8'h41, 8'hFF, RND};
    vecs[11] = '{8'h30, 8'h30, 8'h90, 1'b0};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    #1;
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_product", {24'd0, o_product}, 32'd0);
    chk("reset_overflow", {31'd0, o_overflow}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // saturated result and flag hold after the strobe
    run_vec(vecs[1], 100);
    repeat (3) @(posedge i_clk);
    #1;
    chk("hold_valid_low", {31'd0, o_valid}, 32'd0);
    chk("hold_product", {24'd0, o_product}, 32'hFF);
    chk("hold_overflow", {31'd0, o_overflow}, 32'd1);

    // busy: a mid-RUN pulse is ignored, then an i_valid held in the o_valid cycle is accepted
    start(8'h20, 8'h20);
    repeat (3) @(posedge i_clk);
    #1;
    i_multiplicand = 8'h30;
    i_multiplier   = 8'h30;
    i_valid        = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    wait_result(lat);
    chk("busy_latency", (lat < 0) ? lat : lat + 4, 9);
    chk("busy_product", {24'd0, o_product}, 32'h40);
    chk("busy_overflow", {31'd0, o_overflow}, 32'd0);
    i_multiplicand = 8'h30;
    i_multiplier   = 8'h30;
    i_valid        = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("b2b_ready_low", {31'd0, o_ready}, 32'd0);
    wait_result(lat);
    chk("b2b_latency", lat, 9);
    chk("b2b_product", {24'd0, o_product}, 32'h90);

    // asynchronous reset in the middle of RUN
    start(8'hFF, 8'hFF);
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("midrun_reset_ready", {31'd0, o_ready}, 32'd1);
    chk("midrun_reset_valid", {31'd0, o_valid}, 32'd0);
    chk("midrun_reset_product", {24'd0, o_product}, 32'd0);
    chk("midrun_reset_overflow", {31'd0, o_overflow}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge i_clk);
      #1;
      if (o_valid) seen++;
    end
    chk("no_valid_after_reset", seen, 0);
    run_vec(vecs[0], 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
